// File: rtl/data_responder_if.sv
// data_responder_if: request/response bundle between a load/store requester
// and the data_responder memory.
//   master modport: requester side (drives req_*, resp_ready)
//   slave  modport: responder side (drives req_ready, resp_*)
// Parameter xlen sets data/address width; req_wstrb is xlen/8 bits wide.
interface data_responder_if #(
   parameter int xlen = 64
);
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [xlen-1:0]     req_addr;
   logic [xlen-1:0]     req_wdata;
   logic [xlen/8-1:0]   req_wstrb;
   logic                resp_valid;
   logic                resp_ready;
   logic [xlen-1:0]     resp_rdata;
   logic                resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_responder.sv
// data_responder: single-outstanding memory responder for the core's data port.
// Accepts one load/store, waits `latency` cycles, performs the access on a
// word-addressed array with byte strobes, then holds a response until taken.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset (clears FSM, response and array)
//   bus   - data_responder_if.slave: req_* in / req_ready out,
//           resp_valid/resp_rdata/resp_err out / resp_ready in
module data_responder #(
   parameter int xlen    = 64,
   parameter int depth   = 256,
   parameter int latency = 2
) (
   input  logic               clk,
   input  logic               rstn,
   data_responder_if.slave    bus
);
   localparam int              strb_w  = xlen / 8;
   localparam int              idx_w   = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [xlen-1:0] depth_c = xlen'(depth);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_wait = 2'd1,
      st_resp = 2'd2
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic [3:0]          cnt_r;
   logic                write_r;
   logic [xlen-1:0]     addr_r;
   logic [xlen-1:0]     wdata_r;
   logic [strb_w-1:0]   wstrb_r;
   logic [xlen-1:0]     rdata_r;
   logic                err_r;
   logic [xlen-1:0]     mem_r [depth];

   logic                accept_s;
   logic                access_s;
   logic                err_s;
   logic [xlen-1:0]     word_idx_s;
   logic [idx_w-1:0]    idx_s;
   logic                req_ready_s;
   logic                resp_valid_s;

   // Decode accept/access strobes and classify the latched address
   always_comb begin
      accept_s   = bus.req_valid && (state_r == st_idle);
      access_s   = (state_r == st_wait) && (cnt_r == 4'd0);
      word_idx_s = {3'b000, addr_r[xlen-1:3]};
      err_s      = (addr_r[2:0] != 3'd0) || (word_idx_s >= depth_c);
      // Only meaningful when err_s is clear; out-of-range indices never reach the array
      idx_s      = addr_r[idx_w+2:3];
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= st_idle;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         st_idle: begin
            if (bus.req_valid) next_state_s = st_wait;
            else               next_state_s = st_idle;
         end
         st_wait: begin
            if (cnt_r == 4'd0) next_state_s = st_resp;
            else               next_state_s = st_wait;
         end
         st_resp: begin
            if (bus.resp_ready) next_state_s = st_idle;
            else                next_state_s = st_resp;
         end
         default: next_state_s = st_idle;
      endcase
   end

   // Output decode from registered state only
   always_comb begin
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      case (state_r)
         st_idle: req_ready_s  = 1'b1;
         st_wait: req_ready_s  = 1'b0;
         st_resp: resp_valid_s = 1'b1;
         default: begin
            req_ready_s  = 1'b0;
            resp_valid_s = 1'b0;
         end
      endcase
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = resp_valid_s;
   assign bus.resp_rdata = rdata_r;
   assign bus.resp_err   = err_r;

   // Request capture and wait-state counter (loaded only on accept, stops at 0)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r   <= 4'd0;
         write_r <= 1'b0;
         addr_r  <= {xlen{1'b0}};
         wdata_r <= {xlen{1'b0}};
         wstrb_r <= {strb_w{1'b0}};
      end else if (accept_s) begin
         cnt_r   <= 4'(latency);
         write_r <= bus.req_write;
         addr_r  <= bus.req_addr;
         wdata_r <= bus.req_wdata;
         wstrb_r <= bus.req_wstrb;
      end else if ((state_r == st_wait) && (cnt_r != 4'd0)) begin
         cnt_r   <= cnt_r - 4'd1;
      end
   end

   // Response registers, captured at the access edge and held until handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_r <= {xlen{1'b0}};
         err_r   <= 1'b0;
      end else if (access_s) begin
         err_r   <= err_s;
         rdata_r <= (err_s || write_r) ? {xlen{1'b0}} : mem_r[idx_s];
      end
   end

   // Storage array: cleared on reset, byte-masked write on a good store
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < depth; i++) begin
            mem_r[i] <= {xlen{1'b0}};
         end
      end else if (access_s && write_r && !err_s) begin
         for (int b = 0; b < strb_w; b++) begin
            if (wstrb_r[b]) begin
               mem_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_data_responder.sv
// Scoreboard bench for data_responder: a driver pushes reference-model
// expectations on each accepted request; a monitor pops and compares each
// response, its timing, and its stability under backpressure.
module tb_data_responder;
   localparam int XLEN  = 64;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   data_responder_if #(.xlen(XLEN)) bus0 ();
   data_responder_if #(.xlen(XLEN)) bus1 ();

   data_responder #(.xlen(XLEN), .depth(DEPTH), .latency(LAT)) dut0 (
      .clk(clk), .rstn(rstn), .bus(bus0)
   );
   data_responder #(.xlen(XLEN), .depth(DEPTH), .latency(0)) dut1 (
      .clk(clk), .rstn(rstn), .bus(bus1)
   );

   exp_t        exp_q [$];
   logic [63:0] model_mem [DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rr_mode  = 1;
   logic        rr_val   = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed rules applied to a word array
   function automatic exp_t ref_access(input logic w, input logic [63:0] addr,
                                       input logic [63:0] wdata, input logic [7:0] wstrb);
      exp_t e;
      logic [63:0] idx;
      idx     = addr / 64'd8;
      e.acc   = 0;
      e.rdata = 64'd0;
      e.err   = ((addr % 64'd8) != 64'd0) || (idx >= 64'(DEPTH));
      if (!e.err) begin
         if (w) begin
            for (int b = 0; b < 8; b++) begin
               if (wstrb[b]) model_mem[int'(idx)][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            e.rdata = model_mem[int'(idx)];
         end
      end
      return e;
   endfunction

   task automatic do_req(input logic w, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
      int   n;
      exp_t e;
      @(negedge clk);
      bus0.req_valid = 1'b1;
      bus0.req_write = w;
      bus0.req_addr  = addr;
      bus0.req_wdata = wdata;
      bus0.req_wstrb = wstrb;
      n = 0;
      while (!bus0.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus0.req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready 0 expected 1 within 200 cycles");
         bus0.req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         e     = ref_access(w, addr, wdata, wstrb);
         e.acc = cyc;
         exp_q.push_back(e);
         bus0.req_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus0.resp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   // resp_ready driver: forced value or ~70% random acceptance
   initial begin
      bus0.resp_ready = 1'b1;
      bus1.resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus0.resp_ready = (rr_mode == 1) ? rr_val : ($urandom_range(0, 99) < 70);
      end
   end

   // Monitor: pop on each new response, check latency, hold and ready rules
   initial begin
      logic        seen;
      logic        prev_hs;
      logic [63:0] held_d;
      logic        held_e;
      exp_t        e;
      seen    = 1'b0;
      prev_hs = 1'b0;
      held_d  = 64'd0;
      held_e  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            seen    = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (prev_hs) begin
               check("ready_after_hs", 64'(bus0.req_ready), 64'd1);
               check("valid_clear_after_hs", 64'(bus0.resp_valid), 64'd0);
            end
            if (bus0.resp_valid) begin
               check("ready_low_in_resp", 64'(bus0.req_ready), 64'd0);
               if (!seen) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_resp: got response expected none");
                  end else begin
                     e = exp_q.pop_front();
                     check("rdata", bus0.resp_rdata, e.rdata);
                     check("err", 64'(bus0.resp_err), 64'(e.err));
                     check("latency", 64'(cyc - e.acc), 64'(LAT + 1));
                  end
                  held_d = bus0.resp_rdata;
                  held_e = bus0.resp_err;
                  seen   = 1'b1;
               end else begin
                  check("hold_rdata", bus0.resp_rdata, held_d);
                  check("hold_err", 64'(bus0.resp_err), 64'(held_e));
               end
            end else begin
               seen = 1'b0;
            end
            prev_hs = bus0.resp_valid && bus0.resp_ready;
         end
      end
   end

   // Main stimulus sequence
   initial begin
      logic        w;
      logic [63:0] addr;
      int          sel;
      int          k;
      int          first_v;

      bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 64'd0;
      bus0.req_wdata = 64'd0; bus0.req_wstrb = 8'd0;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 64'd0;
      bus1.req_wdata = 64'd0; bus1.req_wstrb = 8'd0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;

      repeat (3) @(negedge clk);
      check("rst_req_ready0", 64'(bus0.req_ready), 64'd1);
      check("rst_resp_valid0", 64'(bus0.resp_valid), 64'd0);
      check("rst_rdata0", bus0.resp_rdata, 64'd0);
      check("rst_err0", 64'(bus0.resp_err), 64'd0);
      check("rst_req_ready1", 64'(bus1.req_ready), 64'd1);
      check("rst_resp_valid1", 64'(bus1.resp_valid), 64'd0);
      rstn = 1'b1;

      // Directed store/load, partial strobe and error cases
      rr_mode = 1; rr_val = 1'b1;
      do_req(1'b1, 64'h10,  64'h1122334455667788, 8'hFF);
      do_req(1'b0, 64'h10,  64'd0,                8'h00);
      do_req(1'b1, 64'h10,  64'hAAAAAAAABBBBBBBB, 8'h0F);
      do_req(1'b0, 64'h10,  64'd0,                8'h00);
      do_req(1'b0, 64'h13,  64'd0,                8'h00);
      do_req(1'b1, 64'h13,  64'hDEADBEEFCAFEF00D, 8'hFF);
      do_req(1'b0, 64'h10,  64'd0,                8'hFF);
      do_req(1'b0, 64'h800, 64'd0,                8'h00);
      do_req(1'b0, 64'h7F8, 64'd0,                8'h00);
      wait_drain();

      // Backpressure: response held 5 cycles, an intruding request ignored
      rr_val = 1'b0;
      do_req(1'b0, 64'h10, 64'd0, 8'h00);
      k = 0;
      while (!bus0.resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("bp_resp_valid", 64'(bus0.resp_valid), 64'd1);
      repeat (2) @(negedge clk);
      bus0.req_valid = 1'b1; bus0.req_write = 1'b1;
      bus0.req_addr  = 64'h0; bus0.req_wdata = 64'h5555555555555555; bus0.req_wstrb = 8'hFF;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rr_val = 1'b1;
      wait_drain();
      do_req(1'b0, 64'h0, 64'd0, 8'h00);
      wait_drain();

      // Reset during WAIT of a store
      do_req(1'b1, 64'h8, 64'h000000000000FFFF, 8'hFF);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_req_ready", 64'(bus0.req_ready), 64'd1);
      check("midrst_resp_valid", 64'(bus0.resp_valid), 64'd0);
      check("midrst_rdata", bus0.resp_rdata, 64'd0);
      check("midrst_err", 64'(bus0.resp_err), 64'd0);
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      do_req(1'b0, 64'h8, 64'd0, 8'h00);
      do_req(1'b0, 64'h10, 64'd0, 8'h00);
      wait_drain();

      // Zero-latency instance: response one cycle after accept, spacing 3
      @(negedge clk);
      bus1.req_write = 1'b0; bus1.req_addr = 64'h0; bus1.req_wstrb = 8'h00;
      bus1.req_valid = 1'b1;
      check("z_ready", 64'(bus1.req_ready), 64'd1);
      first_v = -1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (bus1.resp_valid && first_v < 0) begin
            first_v = k;
            check("z_rdata", bus1.resp_rdata, 64'd0);
            check("z_err", 64'(bus1.resp_err), 64'd0);
         end
      end while (!bus1.req_ready && k < 20);
      check("z_first_valid", 64'(first_v), 64'd2);
      check("z_spacing", 64'(k), 64'd3);
      @(posedge clk);
      #1;
      bus1.req_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Randomized traffic with random backpressure
      rr_mode = 0;
      for (int t = 0; t < 200; t++) begin
         w   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel < 7)      addr = 64'($urandom_range(0, 15)) * 64'd8;
         else if (sel < 9) addr = 64'($urandom_range(0, 127)) * 64'd8 + 64'($urandom_range(1, 7));
         else              addr = 64'($urandom_range(256, 300)) * 64'd8;
         do_req(w, addr, {32'($urandom), 32'($urandom)}, 8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rr_mode = 1; rr_val = 1'b1;
      wait_drain();
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
